// File: rtl/lsm_pkg.sv
// Shared definitions for the LM/SM multi-register sequencer.
// Holds the opcode constants, the FSM state encoding and an opcode decode helper.
// Only types and constants live here, so it adds no logic and no latency.
package lsm_pkg;

  localparam logic [3:0] OP_LM = 4'b1100;
  localparam logic [3:0] OP_SM = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // True for the two opcodes this sequencer executes.
  function automatic logic is_lsm_op(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lsm_pri_enc.sv
// Lowest-set-bit priority encoder over the register-ordered mask remainder.
// Purely combinational, so it adds no cycles of latency.
// It has no handshake; the caller decides when the result is used.
module lsm_pri_enc #(
  parameter int MASK_W = 8,
  parameter int IDX_W  = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic [MASK_W-1:0] mask_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/lsm_sequencer.sv
// LM/SM sequencer: one memory micro-op per selected register, ascending r, sequential addresses.
// Latency: first micro-op one cycle after accept; one micro-op per cycle when uop_ready is high.
// Backpressure: uop_* outputs hold while uop_valid & !uop_ready; new starts are taken only in IDLE.
module lsm_sequencer
  import lsm_pkg::*;
#(
  parameter int MASK_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1,
  parameter int REG_IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [15:0]          instr,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 flush,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic                 uop_is_load,
  output logic [REG_IDX_W-1:0] uop_reg,
  output logic [ADDR_W-1:0]    uop_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic                 rf_wr_en,
  output logic                 busy,
  output logic                 done
);

  state_e                 state_q, state_d;
  logic [MASK_W-1:0]      rmask_q, rmask_d;   // registers still to issue, bit r = register r
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [REG_IDX_W-1:0]   reg_q, reg_d;
  logic                   vld_q, vld_d;
  logic                   ld_q, ld_d;
  logic                   done_q, done_d;
  logic                   busy_q;

  logic [MASK_W-1:0]      mask_in;            // instruction mask reordered so bit r = register r
  logic [MASK_W-1:0]      enc_in;
  logic [REG_IDX_W-1:0]   enc_idx;
  logic                   enc_any;
  logic [MASK_W-1:0]      enc_onehot;
  logic [11:0]            unused_instr_bits;

  assign unused_instr_bits = instr[11:0];

  // The instruction's mask is MSB-first: register r sits at bit MASK_W-1-r.
  always_comb begin
    mask_in = '0;
    for (int r = 0; r < MASK_W; r++) begin
      mask_in[r] = instr[MASK_W-1-r];
    end
  end

  // In IDLE the encoder looks at the incoming mask to pick the first register;
  // afterwards it looks at what remains after the register currently presented.
  assign enc_in     = (state_q == IDLE) ? mask_in : rmask_q;
  assign enc_onehot = MASK_W'(1) << enc_idx;

  lsm_pri_enc #(
    .MASK_W (MASK_W),
    .IDX_W  (REG_IDX_W)
  ) u_pri_enc (
    .mask_i (enc_in),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  // Next-state and next-output logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    rmask_d = rmask_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    vld_d   = vld_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      rmask_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid && is_lsm_op(instr[15:12])) begin
            ld_d   = (instr[15:12] == OP_LM);
            addr_d = base_addr;
            if (enc_any) begin
              state_d = RUN;
              vld_d   = 1'b1;
              reg_d   = enc_idx;
              rmask_d = mask_in & ~enc_onehot;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
              rmask_d = '0;
            end
          end
        end
        RUN: begin
          if (uop_ready) begin
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            if (enc_any) begin
              reg_d   = enc_idx;
              rmask_d = rmask_q & ~enc_onehot;
            end else begin
              state_d = FIN;
              vld_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          vld_d   = 1'b0;
          rmask_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rmask_q <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      vld_q   <= 1'b0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rmask_q <= rmask_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      vld_q   <= vld_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign start_ready = (state_q == IDLE);
  assign uop_valid   = vld_q;
  assign uop_is_load = ld_q;
  assign uop_reg     = reg_q;
  assign uop_addr    = addr_q;
  assign mem_rd_en   = vld_q & ld_q;
  assign rf_wr_en    = vld_q & ld_q;
  assign mem_wr_en   = vld_q & ~ld_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
